core_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I datapath (decode -> regfile -> alu).

---
 rtl/core_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// ============================================================================
// core_seq_ctrl
// ----------------------------------------------------------------------------
// Multi-cycle sequencer for the RV32I datapath (decode -> regfile -> alu).
// It fetches one instruction at a time over a req/ack instruction-memory port
// and holds the word stable in 'inst' for decode. It pulses the regfile write
// enable once per instruction and advances the PC, either sequentially or to a
// taken branch target.
//
// State flow: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH ...
// HALT is terminal and can only be left through the reset input.
// With an ack in the first FETCH cycle, each instruction takes 4 cycles.
//
// Parameters
//   RESET_PC       PC value loaded on reset
//   FETCH_TIMEOUT  FETCH cycles allowed without imem_ack before error halt (>=2)
//
// Ports
//   clk         in   1   clock, rising edge
//   rest        in   1   reset, asynchronous, active-high
//   start       in   1   begin execution; only looked at in IDLE
//   imem_req    out  1   instruction fetch request (high throughout FETCH)
//   imem_addr   out  32  fetch address, always equal to pc
//   imem_ack    in   1   fetch complete; imem_rdata valid in the same cycle
//   imem_rdata  in   32  fetched instruction word
//   inst        out  32  latched instruction presented to decode
//   br_taken    in   1   branch decision from alu/branch unit, valid in EXEC
//   br_target   in   32  next PC when br_taken, valid in EXEC
//   rf_we       out  1   regfile write enable, single-cycle pulse in WB
//   pc          out  32  current PC
//   busy        out  1   high in every state except IDLE and HALT
//   halted      out  1   high in HALT
//   err         out  1   sticky: fetch timeout or misaligned branch target
//
// Optional feature (macro CTRL_PERF_CNT_EN)
//   When defined, two extra outputs appear:
//     cycle_cnt    [31:0]  increments on every cycle with busy=1
//     instret_cnt  [31:0]  increments on every WB cycle
//   Both clear on reset, wrap at 2^32 and hold still in IDLE/HALT.
//   When undefined, the ports and counters are absent and nothing else
//   changes.
// ============================================================================
module core_seq_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        err
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    // Reset value of the instruction register is the canonical nop (addi x0,x0,0),
    // so decode never sees garbage before the first fetch completes.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // The counter only has to reach FETCH_TIMEOUT-1, so clog2 bits are enough.
    localparam int                CNT_W    = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [CNT_W-1:0] cnt;
    logic             br_taken_q;
    logic [31:0]      br_target_q;

    // Load/update strobes produced by the next-state logic for the datapath registers.
    logic             inst_load;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             err_set;
    logic             br_load;
    logic             pc_load;
    logic             writes_rd;

    // The PC drives the fetch address directly; it only changes in WB,
    // so the address stays stable for the whole FETCH phase.
    assign imem_addr = pc;

    // A write to the register file happens only when the instruction
    // produces a result and the destination is not x0.
    assign writes_rd = (inst[6:0] != OPC_STORE) &&
                       (inst[6:0] != OPC_BRANCH) &&
                       (inst[11:7] != 5'd0);

    // State register. Because reset is asynchronous, imem_req (decoded from
    // the state) drops as soon as reset asserts, even in the middle of a fetch.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. Every output and strobe gets its idle
    // value first, and each state then raises only what it needs.
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        rf_we      = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        inst_load  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;
        br_load    = 1'b0;
        pc_load    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                end
            end

            // An ack always takes priority, including in the last allowed
            // cycle, so a slow but successful fetch is never flagged.
            FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_ack) begin
                    inst_load  = 1'b1;
                    cnt_clr    = 1'b1;
                    next_state = DECODE;
                end else if (cnt == CNT_LAST) begin
                    err_set    = 1'b1;
                    cnt_clr    = 1'b1;
                    next_state = HALT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            DECODE: begin
                busy       = 1'b1;
                next_state = EXEC;
            end

            // ECALL/EBREAK is a clean stop, so it is checked before the branch
            // alignment test. It halts without an error and leaves the PC alone.
            EXEC: begin
                busy    = 1'b1;
                br_load = 1'b1;
                if (inst[6:0] == OPC_SYSTEM) begin
                    next_state = HALT;
                end else if (br_taken && (br_target[1:0] != 2'b00)) begin
                    err_set    = 1'b1;
                    next_state = HALT;
                end else begin
                    next_state = WB;
                end
            end

            WB: begin
                busy       = 1'b1;
                rf_we      = writes_rd;
                pc_load    = 1'b1;
                next_state = FETCH;
            end

            HALT: begin
                halted = 1'b1;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers: PC, instruction latch, timeout counter, captured
    // branch outcome and the sticky error flag. Outside the strobes above they
    // hold their value, which keeps pc and inst frozen in HALT.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            pc          <= RESET_PC;
            inst        <= NOP_INST;
            cnt         <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= 32'h0000_0000;
            err         <= 1'b0;
        end else begin
            if (inst_load) begin
                inst <= imem_rdata;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (br_load) begin
                br_taken_q  <= br_taken;
                br_target_q <= br_target;
            end
            if (err_set) begin
                err <= 1'b1;
            end
            // The sequential step relies on natural 32-bit wrap, so 0xFFFF_FFFC goes to 0.
            if (pc_load) begin
                pc <= br_taken_q ? br_target_q : (pc + 32'd4);
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Performance counters. Both key off the decoded state, so they stop
    // automatically in IDLE and HALT.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            cycle_cnt   <= 32'h0000_0000;
            instret_cnt <= 32'h0000_0000;
        end else begin
            if (busy) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (state == WB) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// ============================================================================
// tb_core_seq_ctrl
// ----------------------------------------------------------------------------
// Directed bench for core_seq_ctrl. The bench plays the role of the
// instruction memory and the branch unit, walks the sequencer through
// reset, normal execution, branches, halts and timeouts, and compares the
// outputs with hand-computed values.
// ============================================================================
module tb_core_seq_ctrl;

    logic        clk;
    logic        rest;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        rf_we;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
    logic        err;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    int assertCount = 0;
    int failCount   = 0;

    core_seq_ctrl #(
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rest       (rest),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .rf_we      (rf_we),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .err        (err)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, which is where the bench
    // samples outputs and drives new inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare a 32-bit value and count the comparison.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Compare a single bit and count the comparison.
    task automatic checkBit(input string tag, input logic obs, input logic exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Hold reset for two edges, then release it just after an edge.
    task automatic resetDut();
        rest = 1'b1;
        tick();
        tick();
        rest = 1'b0;
    endtask

    // Pulse start from IDLE; on return the sequencer is in its first FETCH cycle.
    task automatic startDut();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run one full instruction from the start of its FETCH phase. The memory
    // acks after 'waits' empty cycles. On return the sequencer is at the start
    // of the next FETCH.
    task automatic applyStimulus(input string tag, input logic [31:0] word, input int waits,
                                 input logic taken, input logic [31:0] target,
                                 input logic [31:0] expAddr, input logic expWe,
                                 input logic [31:0] expPc);
        imem_ack = 1'b0;
        for (int i = 0; i < waits; i++) begin
            tick();
        end
        checkBit({tag, " imem_req"}, imem_req, 1'b1);
        checkOutput({tag, " imem_addr"}, imem_addr, expAddr);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack = 1'b0;
        checkOutput({tag, " inst"}, inst, word);
        checkBit({tag, " req drop"}, imem_req, 1'b0);
        br_taken  = taken;
        br_target = target;
        tick();
        tick();
        checkBit({tag, " rf_we"}, rf_we, expWe);
        br_taken  = 1'b0;
        br_target = 32'h0;
        tick();
        checkBit({tag, " rf_we pulse end"}, rf_we, 1'b0);
        checkOutput({tag, " pc"}, pc, expPc);
    endtask

    initial begin
        rest       = 1'b1;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        br_taken   = 1'b0;
        br_target  = 32'h0;

        // ---- Reset state ----
        #2;
        checkOutput("reset pc", pc, 32'h0000_0000);
        checkOutput("reset inst", inst, 32'h0000_0013);
        checkBit("reset imem_req", imem_req, 1'b0);
        checkBit("reset rf_we", rf_we, 1'b0);
        checkBit("reset busy", busy, 1'b0);
        checkBit("reset halted", halted, 1'b0);
        checkBit("reset err", err, 1'b0);
        resetDut();

        // ---- IDLE waits until start ----
        tick();
        checkBit("idle busy", busy, 1'b0);
        startDut();
        checkBit("fetch busy", busy, 1'b1);

        // ---- Program stream with 0..3 wait cycles ----
        applyStimulus("i0 addi", 32'h0090_0513, 0, 1'b0, 32'h0, 32'h00, 1'b1, 32'h04);
`ifdef CTRL_PERF_CNT_EN
        checkOutput("perf instret", instret_cnt, 32'd1);
        checkOutput("perf cycle", cycle_cnt, 32'd4);
`endif
        start = 1'b1;
        applyStimulus("i1 addi", 32'h0060_0593, 1, 1'b0, 32'h0, 32'h04, 1'b1, 32'h08);
        start = 1'b0;
        applyStimulus("i2 add", 32'h00b5_0633, 2, 1'b0, 32'h0, 32'h08, 1'b1, 32'h0C);
        applyStimulus("i3 sub", 32'h40b5_06b3, 3, 1'b0, 32'h0, 32'h0C, 1'b1, 32'h10);
        applyStimulus("i4 and", 32'h00d6_7733, 0, 1'b0, 32'h0, 32'h10, 1'b1, 32'h14);

        // ---- No write for rd=x0 and for stores ----
        applyStimulus("nop rd0", 32'h0000_0013, 0, 1'b0, 32'h0, 32'h14, 1'b0, 32'h18);
        applyStimulus("store", 32'h00a1_2023, 1, 1'b0, 32'h0, 32'h18, 1'b0, 32'h1C);

        // ---- Taken branch to top of memory, then sequential wrap to 0 ----
        applyStimulus("br top", 32'h0000_0463, 0, 1'b1, 32'hFFFF_FFFC, 32'h1C, 1'b0, 32'hFFFF_FFFC);
        applyStimulus("wrap", 32'h0090_0513, 0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000);

        // ---- Aligned taken branch ----
        applyStimulus("br 0x40", 32'h0000_0463, 0, 1'b1, 32'h40, 32'h00, 1'b0, 32'h40);

        // ---- Misaligned taken branch halts with error ----
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0463;
        tick();
        imem_ack  = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h42;
        tick();
        checkBit("misalign exec halted", halted, 1'b0);
        tick();
        br_taken  = 1'b0;
        br_target = 32'h0;
        checkBit("misalign halted", halted, 1'b1);
        checkBit("misalign err", err, 1'b1);
        checkBit("misalign rf_we", rf_we, 1'b0);
        checkBit("misalign busy", busy, 1'b0);
        checkOutput("misalign pc", pc, 32'h40);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checkBit("halt ignores start", halted, 1'b1);
        checkBit("halt imem_req", imem_req, 1'b0);
        checkOutput("halt pc frozen", pc, 32'h40);
        checkOutput("halt inst frozen", inst, 32'h0000_0463);

        // ---- Fetch timeout: no ack for 16 FETCH cycles ----
        resetDut();
        checkBit("reset clears err", err, 1'b0);
        startDut();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        checkBit("timeout cycle16 req", imem_req, 1'b1);
        checkBit("timeout cycle16 halted", halted, 1'b0);
        tick();
        checkBit("timeout halted", halted, 1'b1);
        checkBit("timeout err", err, 1'b1);
        checkBit("timeout imem_req", imem_req, 1'b0);

        // ---- Ack in the last allowed cycle wins; ECALL halts cleanly ----
        resetDut();
        startDut();
        applyStimulus("pre ecall", 32'h0090_0513, 0, 1'b0, 32'h0, 32'h00, 1'b1, 32'h04);
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0073;
        tick();
        imem_ack = 1'b0;
        checkBit("late ack no err", err, 1'b0);
        checkOutput("ecall inst", inst, 32'h0000_0073);
        tick();
        tick();
        checkBit("ecall halted", halted, 1'b1);
        checkBit("ecall err", err, 1'b0);
        checkBit("ecall rf_we", rf_we, 1'b0);
        checkOutput("ecall pc", pc, 32'h04);

        // ---- Reset asserted in the middle of a fetch ----
        resetDut();
        startDut();
        applyStimulus("pre midreset", 32'h0090_0513, 0, 1'b0, 32'h0, 32'h00, 1'b1, 32'h04);
        tick();
        rest = 1'b1;
        #1;
        checkBit("midreset imem_req", imem_req, 1'b0);
        checkBit("midreset busy", busy, 1'b0);
        checkOutput("midreset pc", pc, 32'h0);
        checkOutput("midreset inst", inst, 32'h0000_0013);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0060_0593;
        tick();
        rest = 1'b0;
        tick();
        imem_ack = 1'b0;
        checkBit("late ack ignored busy", busy, 1'b0);
        checkOutput("late ack ignored inst", inst, 32'h0000_0013);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
